// File: rtl/id_pkg.sv
`default_nettype none
// =============================================================================
// id_pkg : shared decode-stage types and instruction field positions   Rev 1.0
// =============================================================================
package id_pkg;

    typedef struct packed {
        logic reg_dst;
        logic reg_wr;
        logic alu_src;
        logic imm_zero;
        logic ext_op;
        logic mem_to_reg;
        logic mem_wr;
        logic jal;
    } id_ctrl_t;

    // Instruction word is numbered MSB-first, bit 0 is the most significant
    localparam int RS_MSB  = 6;
    localparam int RS_LSB  = 10;
    localparam int RT_MSB  = 11;
    localparam int RT_LSB  = 15;
    localparam int RD_MSB  = 16;
    localparam int RD_LSB  = 20;
    localparam int IMM_MSB = 16;
    localparam int IMM_LSB = 31;

    localparam logic [4:0] REG_LINK = 5'd31;

endpackage
`default_nettype wire

// File: rtl/id_regfile.sv
`default_nettype none
// =============================================================================
// id_regfile : NREGS x XLEN GPR file, 2 read / 1 write, write-through bypass
// Rev 1.0
// =============================================================================
module id_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rd_addr_a,
    output logic [0:XLEN-1] rd_data_a,
    input  logic [4:0]      rd_addr_b,
    output logic [0:XLEN-1] rd_data_b,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [0:XLEN-1] wb_data
);

    // r0 is hard-wired to zero, so no storage is built for it
    logic [0:XLEN-1] regs [1:NREGS-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            for (int i = 1; i < NREGS; i++) begin
                if (wb_addr == 5'(i)) begin
                    regs[i] <= wb_data;
                end
            end
        end
    end

    // Same-cycle writeback wins over the stored value; unimplemented addresses read 0
    function automatic logic [0:XLEN-1] read_port(input logic [4:0] addr);
        logic [0:XLEN-1] val;
        val = '0;
        if (addr != 5'd0) begin
            if (wb_en && (wb_addr == addr)) begin
                val = wb_data;
            end else begin
                for (int i = 1; i < NREGS; i++) begin
                    if (addr == 5'(i)) begin
                        val = regs[i];
                    end
                end
            end
        end
        return val;
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_addr_a);
        rd_data_b = read_port(rd_addr_b);
    end

endmodule
`default_nettype wire

// File: rtl/id_pipe_stage.sv
`default_nettype none
// =============================================================================
// id_pipe_stage : instruction decode stage with ID/EX register and handshake
// Optional load-use interlock: define ID_LOAD_INTERLOCK_EN          Rev 1.0
// =============================================================================
module id_pipe_stage
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:31]      instruction,
    input  id_ctrl_t         ctrl_in,
    input  logic             flush,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [0:XLEN-1]  wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:XLEN-1]  out_op_a,
    output logic [0:XLEN-1]  out_op_b,
    output logic [0:XLEN-1]  out_bus_b,
    output logic [4:0]       out_dst,
    output id_ctrl_t         out_ctrl,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [0:15]     imm16;
    logic [0:XLEN-1] imm_ext;
    logic [0:XLEN-1] rs_val;
    logic [0:XLEN-1] rt_val;
    logic [0:XLEN-1] op_b;
    logic [4:0]      dst;
    logic            hazard;
    logic            load;
    logic            unused_opcode;

    assign rs    = instruction[RS_MSB:RS_LSB];
    assign rt    = instruction[RT_MSB:RT_LSB];
    assign rd    = instruction[RD_MSB:RD_LSB];
    assign imm16 = ctrl_in.imm_zero ? 16'h0000 : instruction[IMM_MSB:IMM_LSB];

    assign unused_opcode = &{1'b0, instruction[0:5]};

    // imm16[0] is the sign bit because the word is numbered MSB-first
    assign imm_ext = ctrl_in.ext_op ? {{(XLEN-16){imm16[0]}}, imm16}
                                    : {{(XLEN-16){1'b0}}, imm16};

    id_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (rs),
        .rd_data_a (rs_val),
        .rd_addr_b (rt),
        .rd_data_b (rt_val),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    assign op_b = ctrl_in.alu_src ? imm_ext : rt_val;
    assign dst  = ctrl_in.jal     ? REG_LINK :
                  ctrl_in.reg_dst ? rd       : rt;

`ifdef ID_LOAD_INTERLOCK_EN
    logic uses_rt;

    // A load in ID/EX cannot forward its data yet, so any consumer must wait
    assign uses_rt = !ctrl_in.alu_src || ctrl_in.mem_wr;
    assign hazard  = out_valid && out_ctrl.mem_to_reg && (out_dst != 5'd0) &&
                     ((rs == out_dst) || (uses_rt && (rt == out_dst)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (in_valid && hazard && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign hazard    = 1'b0;
    assign stall_cnt = '0;
`endif

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign load     = in_valid && in_ready;

    // Data fields keep their last value when the stage empties
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_op_a  <= '0;
            out_op_b  <= '0;
            out_bus_b <= '0;
            out_dst   <= '0;
            out_ctrl  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_op_a  <= rs_val;
            out_op_b  <= op_b;
            out_bus_b <= rt_val;
            out_dst   <= dst;
            out_ctrl  <= ctrl_in;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
